fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the fetch and decode stages.
// Circular buffer of DEPTH {pc, instr} entries with valid/ready handshakes on
// both sides, a flush input that discards every queued entry, and a
// saturating counter of entries lost to flushes.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   push handshake; in_pc/in_instr carry the entry
//   out_valid/out_ready pop handshake; out_pc/out_instr/out_pca4 show the
//                       head entry (all zero while the queue is empty)
//   flush               discard all entries (reset > flush > push/pop)
//   count               occupied entries, 0..DEPTH
//   drop_cnt            saturating count of entries discarded by flush
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pca4,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic [CW-1:0] drop_add;
  logic [8:0]    drop_sum;
  logic          push, pop;

  // Flow control depends only on registered occupancy, so there is no
  // combinational path between the two sides of the queue.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // Head fields are masked while empty so stale storage never leaks out.
  assign out_pc    = out_valid ? pc_mem[head_q]             : '0;
  assign out_instr = out_valid ? instr_mem[head_q]          : '0;
  assign out_pca4  = out_valid ? (pc_mem[head_q] + 32'd4)   : '0;

  assign count    = count_q;
  assign drop_cnt = drop_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // An entry popped in the flush cycle was consumed, not dropped.
  always_comb begin
    drop_add = pop ? (count_q - CW'(1)) : count_q;
    drop_sum = {1'b0, drop_q} + 9'(drop_add);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= drop_d;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps to 0.
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is not reset; contents are hidden by the out_valid mask.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_mem[tail_q]    <= in_pc;
      instr_mem[tail_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver applies directed and random
// stimulus and maintains the expected queue contents; a monitor compares the
// DUT outputs against the expected state every cycle.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_instr, out_pca4;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_pca4(out_pca4),
    .flush(flush), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  entry_t      exp_q[$];
  int unsigned exp_drop = 0;
  bit          started = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample away from the rising edge and compare with expectations.
  always @(negedge clk) begin
    if (started) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      chk("drop_cnt", 32'(drop_cnt), exp_drop);
      if (exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_instr", out_instr, exp_q[0].instr);
        chk("out_pca4", out_pca4, exp_q[0].pc + 32'd4);
      end else begin
        chk("out_pc_zero", out_pc, 32'd0);
        chk("out_instr_zero", out_instr, 32'd0);
        chk("out_pca4_zero", out_pca4, 32'd0);
      end
    end
  end

  // One clock cycle of stimulus; the expected queue is updated by the
  // queue rules applied to the pre-edge occupancy.
  task automatic cyc(input bit rst_n, input bit iv, input logic [31:0] pc,
                     input logic [31:0] ins, input bit ordy, input bit fl);
    int unsigned sz;
    bit          do_pop;
    reset = rst_n; in_valid = iv; in_pc = pc; in_instr = ins;
    out_ready = ordy; flush = fl;
    sz = exp_q.size();
    do_pop = (sz != 0) && ordy;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      exp_drop = 0;
    end else if (fl) begin
      exp_drop = exp_drop + sz - (do_pop ? 1 : 0);
      if (exp_drop > 255) exp_drop = 255;
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (iv && sz < DEPTH) exp_q.push_back('{pc, ins});
    end
    #1;
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    started = 1;
  endtask

  initial begin
    logic [31:0] pc;
    pc = 32'h3000;
    do_reset();

    // single push, immediate visibility
    cyc(1, 1, 32'h3000, 32'h3C010001, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // fill to DEPTH, fifth push ignored, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'h3000 + 32'(4 * i), $urandom, 0, 0);
    cyc(1, 1, 32'h3010, 32'hDEADBEEF, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0);

    // steady push+pop at count 2, pointers wrap
    do_reset();
    for (int i = 0; i < 2; i++) begin cyc(1, 1, pc, $urandom, 0, 0); pc += 4; end
    for (int i = 0; i < 10; i++) begin cyc(1, 1, pc, $urandom, 1, 0); pc += 4; end

    // flush at count 3 with concurrent push and pop: drop 2
    do_reset();
    for (int i = 0; i < 3; i++) begin cyc(1, 1, pc, $urandom, 0, 0); pc += 4; end
    cyc(1, 1, pc, $urandom, 1, 1);
    cyc(1, 1, 32'h4000, 32'h12345678, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // saturating drop counter, then reset clears it
    for (int f = 0; f < 70; f++) begin
      for (int i = 0; i < 4; i++) begin cyc(1, 1, pc, $urandom, 0, 0); pc += 4; end
      cyc(1, 0, 0, 0, 0, 1);
    end
    cyc(1, 0, 0, 0, 0, 0);
    do_reset();

    // mid-stream reset discards entries without counting drops
    for (int i = 0; i < 3; i++) begin cyc(1, 1, pc, $urandom, 0, 0); pc += 4; end
    cyc(0, 1, pc, $urandom, 1, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0), $urandom, $urandom,
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
